// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 slice: register indices, field positions
// and exception codes.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  localparam int ST_IE        = 0;
  localparam int ST_EXL       = 1;
  localparam int ST_IM_LO     = 8;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 8;
  localparam int IP_HW_LO     = 2;
  localparam int IP_TI        = 7;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // Never returns less than 1 so a divide-by-one prescaler still has a real register.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/cp0_irq_sync.sv
// Two-flop synchroniser bringing the external interrupt levels into the clk domain.
module cp0_irq_sync #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= '0;
      sync_out <= '0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/cp0_exception_unit.sv
// MIPS coprocessor 0: Status/Cause/EPC/Count/Compare, prescaled timer interrupt,
// synchronised hardware interrupts and exception entry/return sequencing.
module cp0_exception_unit
  import cp0_pkg::*;
#(
  parameter int          N_HW_IRQ    = 5,
  parameter int          COUNT_DIV   = 2,
  parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          rd_addr,
  output logic [31:0]         rdata,
  input  logic                we,
  input  logic [4:0]          wr_addr,
  input  logic [31:0]         wdata,
  input  logic [N_HW_IRQ-1:0] hw_irq,
  input  logic                exc_take,
  input  logic [4:0]          exc_code,
  input  logic [31:0]         exc_pc,
  input  logic                eret,
  output logic                int_req,
  output logic [31:0]         epc,
  output logic                exl
);

  localparam int             PW        = clog2(COUNT_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(COUNT_DIV - 1);

  logic [N_HW_IRQ-1:0] irq_sync;
  logic [31:0]         count_q, compare_q, epc_q;
  logic [PW-1:0]       presc_q;
  logic                ie_q, exl_q, ti_q;
  logic [7:0]          im_q;
  logic [1:0]          ip_sw_q;
  logic [4:0]          exc_code_q;
  logic [7:0]          ip;
  logic [31:0]         count_inc;
  logic                tick, wr_count, wr_compare, wr_status, wr_cause, wr_epc;

  cp0_irq_sync #(.WIDTH(N_HW_IRQ)) u_irq_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (hw_irq),
    .sync_out (irq_sync)
  );

  assign tick       = (presc_q == PRESC_MAX);
  assign count_inc  = count_q + 32'd1;
  assign wr_count   = we && (wr_addr == REG_COUNT);
  assign wr_compare = we && (wr_addr == REG_COMPARE);
  assign wr_status  = we && (wr_addr == REG_STATUS);
  assign wr_cause   = we && (wr_addr == REG_CAUSE);
  assign wr_epc     = we && (wr_addr == REG_EPC);

  always_comb begin
    ip                       = '0;
    ip[1:0]                  = ip_sw_q;
    ip[IP_HW_LO +: N_HW_IRQ] = irq_sync;
    ip[IP_TI]                = ti_q;
  end

  // Later assignments win: eret overrides an MTC0 to EXL, exc_take overrides both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      compare_q  <= COMPARE_RST;
      presc_q    <= '0;
      ti_q       <= 1'b0;
      ie_q       <= 1'b0;
      exl_q      <= 1'b0;
      im_q       <= '0;
      ip_sw_q    <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      if (wr_count) begin
        count_q <= wdata;
        presc_q <= '0;
      end else begin
        presc_q <= tick ? '0 : presc_q + PW'(1);
        if (tick) count_q <= count_inc;
      end
      if (wr_compare) begin
        compare_q <= wdata;
        ti_q      <= 1'b0;
      end else if (tick && !wr_count && (count_inc == compare_q)) begin
        ti_q <= 1'b1;
      end
      if (wr_status) begin
        ie_q  <= wdata[ST_IE];
        exl_q <= wdata[ST_EXL];
        im_q  <= wdata[ST_IM_LO +: 8];
      end
      if (wr_cause) begin
        ip_sw_q    <= wdata[CAUSE_IP_LO +: 2];
        exc_code_q <= wdata[CAUSE_EXC_LO +: 5];
      end
      if (wr_epc) epc_q <= wdata;
      if (eret) exl_q <= 1'b0;
      if (exc_take) begin
        epc_q      <= exc_pc;
        exc_code_q <= exc_code;
        exl_q      <= 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (rd_addr)
      REG_COUNT:   rdata = count_q;
      REG_COMPARE: rdata = compare_q;
      REG_STATUS:  rdata = {16'b0, im_q, 6'b0, exl_q, ie_q};
      REG_CAUSE:   rdata = {16'b0, ip, 1'b0, exc_code_q, 2'b0};
      REG_EPC:     rdata = epc_q;
      default:     rdata = '0;
    endcase
  end

  assign int_req = ie_q && !exl_q && |(ip & im_q);
  assign epc     = epc_q;
  assign exl     = exl_q;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Self-checking bench for cp0_exception_unit: directed vector table, hand-written
// timer/irq/reset sequences, then random traffic against a behavioural model.
module tb_cp0_exception_unit;

  localparam int          N_HW_IRQ    = 5;
  localparam int          COUNT_DIV   = 2;
  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  logic                clk, rst, we, exc_take, eret, int_req, exl;
  logic [4:0]          rd_addr, wr_addr, exc_code;
  logic [31:0]         rdata, wdata, exc_pc, epc;
  logic [N_HW_IRQ-1:0] hw_irq;

  int tests_run = 0;
  int tests_failed = 0;

  cp0_exception_unit #(
    .N_HW_IRQ(N_HW_IRQ), .COUNT_DIV(COUNT_DIV), .COMPARE_RST(COMPARE_RST)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rdata(rdata), .we(we),
    .wr_addr(wr_addr), .wdata(wdata), .hw_irq(hw_irq), .exc_take(exc_take),
    .exc_code(exc_code), .exc_pc(exc_pc), .eret(eret), .int_req(int_req),
    .epc(epc), .exl(exl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wdata;
    logic        exc_take;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        eret;
    logic [4:0]  rd_addr;
    logic [31:0] exp_rdata;
    logic        exp_int_req;
    logic        exp_exl;
  } vec_t;

  // Behavioural model state: architectural fields plus edges since last Count load.
  logic [31:0]         m_count, m_compare, m_epc;
  logic                m_ti, m_ie, m_exl;
  logic [7:0]          m_im;
  logic [1:0]          m_ipsw;
  logic [4:0]          m_code;
  int                  m_edges;
  logic [N_HW_IRQ-1:0] m_hwq[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    we = 1'b1; wr_addr = addr; wdata = data;
    tick();
    we = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    we = v.we; wr_addr = v.wr_addr; wdata = v.wdata;
    exc_take = v.exc_take; exc_code = v.exc_code; exc_pc = v.exc_pc;
    eret = v.eret; rd_addr = v.rd_addr;
    tick();
    we = 1'b0; exc_take = 1'b0; eret = 1'b0;
  endtask

  function automatic logic [7:0] model_ip();
    logic [7:0] ip;
    ip = 8'h00;
    ip[1:0] = m_ipsw;
    for (int i = 0; i < N_HW_IRQ; i++) ip[2+i] = m_hwq[0][i];
    ip[7] = m_ti;
    return ip;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return {16'h0, m_im, 6'h0, m_exl, m_ie};
      5'd13:   return {16'h0, model_ip(), 1'b0, m_code, 2'b00};
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_count = 0; m_compare = COMPARE_RST; m_epc = 0; m_ti = 0; m_ie = 0;
    m_exl = 0; m_im = 0; m_ipsw = 0; m_code = 0; m_edges = 0;
    m_hwq = {};
    m_hwq.push_back('0);
    m_hwq.push_back('0);
  endtask

  // Applies one clock edge's worth of architectural rules using pre-edge inputs.
  task automatic model_step();
    logic [31:0] old_count, old_compare;
    logic        inc;
    old_count   = m_count;
    old_compare = m_compare;
    inc         = 1'b0;
    m_hwq.push_back(hw_irq);
    void'(m_hwq.pop_front());
    if (we && wr_addr == 5'd9) begin
      m_count = wdata;
      m_edges = 0;
    end else begin
      m_edges++;
      inc = ((m_edges % COUNT_DIV) == 0);
      if (inc) m_count = old_count + 32'd1;
    end
    if (we && wr_addr == 5'd11) begin
      m_compare = wdata;
      m_ti = 1'b0;
    end else if (inc && (old_count + 32'd1 == old_compare)) begin
      m_ti = 1'b1;
    end
    if (we && wr_addr == 5'd12) begin
      m_ie = wdata[0]; m_exl = wdata[1]; m_im = wdata[15:8];
    end
    if (we && wr_addr == 5'd13) begin
      m_ipsw = wdata[9:8]; m_code = wdata[6:2];
    end
    if (we && wr_addr == 5'd14) m_epc = wdata;
    if (eret) m_exl = 1'b0;
    if (exc_take) begin
      m_epc = exc_pc; m_code = exc_code; m_exl = 1'b1;
    end
  endtask

  initial begin
    vec_t        tbl[11];
    logic [4:0]  reg_addr[6];
    logic [31:0] rst_val[6];
    logic [31:0] exp_int;

    reg_addr = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
    rst_val  = '{32'h0, COMPARE_RST, 32'h0, 32'h0, 32'h0, 32'h0};

    tbl[0]  = '{1'b1, 5'd12, 32'h0000_FF01, 1'b0, 5'd0,  32'h0,   1'b0, 5'd12, 32'h0000_FF01, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 5'd13, 32'h0000_0300, 1'b0, 5'd0,  32'h0,   1'b0, 5'd13, 32'h0000_0300, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 5'd14, 32'h0000_0099, 1'b1, 5'd8,  32'h40,  1'b0, 5'd14, 32'h0000_0040, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,   1'b0, 5'd13, 32'h0000_0320, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'h80,  1'b1, 5'd12, 32'h0000_FF03, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,   1'b1, 5'd12, 32'h0000_FF01, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 5'd12, 32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0,   1'b0, 5'd12, 32'h0000_FF03, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 5'd13, 32'h0000_0100, 1'b0, 5'd0,  32'h0,   1'b1, 5'd13, 32'h0000_0100, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 5'd3,  32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0,   1'b0, 5'd3,  32'h0000_0000, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 5'd11, 32'h1234_5678, 1'b0, 5'd0,  32'h0,   1'b0, 5'd11, 32'h1234_5678, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 5'd12, 32'h0000_0000, 1'b1, 5'd10, 32'h100, 1'b0, 5'd12, 32'h0000_0002, 1'b0, 1'b1};

    rst = 1'b1; we = 0; wr_addr = 0; wdata = 0; hw_irq = '0; exc_take = 0;
    exc_code = 0; exc_pc = 0; eret = 0; rd_addr = 0;
    tick();
    for (int i = 0; i < 6; i++) begin
      rd_addr = reg_addr[i];
      #1;
      check_output($sformatf("reset_reg%0d", reg_addr[i]), rdata, rst_val[i]);
    end
    check_output("reset_int_req", {31'b0, int_req}, 32'h0);
    check_output("reset_epc", epc, 32'h0);
    check_output("reset_exl", {31'b0, exl}, 32'h0);
    tick();
    rst = 1'b0;

    foreach (tbl[i]) begin
      apply_stimulus(tbl[i]);
      check_output($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rdata);
      check_output($sformatf("vec%0d_int_req", i), {31'b0, int_req}, {31'b0, tbl[i].exp_int_req});
      check_output($sformatf("vec%0d_exl", i), {31'b0, exl}, {31'b0, tbl[i].exp_exl});
    end

    // Timer: Compare=5, Count=0 loaded on edge 0, TI expected on edge 10.
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd13, 32'h0);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    rd_addr = 5'd13;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_int = (k == 10) ? 32'h1 : 32'h0;
      check_output($sformatf("timer_int_k%0d", k), {31'b0, int_req}, exp_int);
      check_output($sformatf("timer_ti_k%0d", k), {31'b0, rdata[15]}, exp_int);
    end
    mtc0(5'd12, 32'h0000_0001);
    check_output("timer_masked", {31'b0, int_req}, 32'h0);
    mtc0(5'd12, 32'h0000_8001);
    check_output("timer_unmasked", {31'b0, int_req}, 32'h1);
    mtc0(5'd11, 32'd20);
    check_output("timer_clear_int", {31'b0, int_req}, 32'h0);
    check_output("timer_clear_ti", {31'b0, rdata[15]}, 32'h0);

    // Hardware line 0: two edges of latency on rise and fall.
    mtc0(5'd12, 32'h0000_0401);
    hw_irq = 5'b00001;
    tick();
    check_output("hw_rise_1", {31'b0, int_req}, 32'h0);
    tick();
    check_output("hw_rise_2", {31'b0, int_req}, 32'h1);
    check_output("hw_rise_ip", {31'b0, rdata[10]}, 32'h1);
    hw_irq = 5'b00000;
    tick();
    check_output("hw_fall_1", {31'b0, int_req}, 32'h1);
    tick();
    check_output("hw_fall_2", {31'b0, int_req}, 32'h0);

    // Asynchronous reset with TI and EXL set and an exc_take pending.
    mtc0(5'd11, 32'd1);
    mtc0(5'd9, 32'd0);
    tick();
    tick();
    mtc0(5'd12, 32'h0000_8003);
    check_output("pre_rst_exl", {31'b0, exl}, 32'h1);
    check_output("pre_rst_ti", {31'b0, rdata[15]}, 32'h1);
    exc_take = 1'b1; exc_code = 5'd8; exc_pc = 32'h1234;
    #2;
    rst = 1'b1;
    #1;
    check_output("midrst_int_req", {31'b0, int_req}, 32'h0);
    check_output("midrst_epc", epc, 32'h0);
    check_output("midrst_exl", {31'b0, exl}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      rd_addr = reg_addr[i];
      #0.5;
      check_output($sformatf("midrst_reg%0d", reg_addr[i]), rdata, rst_val[i]);
    end
    tick();
    exc_take = 1'b0;
    check_output("midrst_exc_lost", epc, 32'h0);

    // Random traffic against the behavioural model.
    model_reset();
    tick();
    rst = 1'b0;
    for (int n = 0; n < 600; n++) begin
      we = ($urandom_range(0, 2) == 0);
      wr_addr = reg_addr[$urandom_range(0, 5)];
      wdata = $urandom;
      if (wr_addr == 5'd11) wdata = m_count + 32'($urandom_range(1, 4));
      if (wr_addr == 5'd9 && $urandom_range(0, 1) == 1) wdata = 32'hFFFF_FFFE;
      exc_take = ($urandom_range(0, 15) == 0);
      eret = ($urandom_range(0, 7) == 0);
      exc_code = 5'($urandom);
      exc_pc = $urandom;
      if ($urandom_range(0, 3) == 0) hw_irq = N_HW_IRQ'($urandom);
      rd_addr = reg_addr[$urandom_range(0, 5)];
      @(posedge clk);
      model_step();
      #1;
      check_output($sformatf("rand%0d_rdata_r%0d", n, rd_addr), rdata, model_read(rd_addr));
      check_output($sformatf("rand%0d_int_req", n), {31'b0, int_req},
                   {31'b0, m_ie & ~m_exl & |(model_ip() & m_im)});
      check_output($sformatf("rand%0d_epc", n), epc, m_epc);
      check_output($sformatf("rand%0d_exl", n), {31'b0, exl}, {31'b0, m_exl});
    end
    we = 0; exc_take = 0; eret = 0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cp0_exception_unit.md
# cp0_exception_unit

Parametrised MIPS coprocessor-0 for the SoC core: holds Status, Cause, EPC, Count and Compare. It adds a free-running prescaled timer with compare interrupt, and synchronised hardware interrupt lines with per-line masking. It also sequences exception entry and return (EXL) against MFC0/MTC0 traffic from the datapath. It sits beside the register file and supplies the interrupt request and EPC to the multicycle controller.

## Interface
Parameters:
- N_HW_IRQ, 5, number of external interrupt lines (1..5); line i maps to Cause.IP[2+i]
- COUNT_DIV, 2, clk cycles per Count increment (>=1)
- COMPARE_RST, 32'hFFFF_FFFF, reset value of Compare

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  5  MFC0 register index
- rdata  out  32  MFC0 data, combinational from rd_addr
- we  in  1  MTC0 write strobe
- wr_addr  in  5  MTC0 register index
- wdata  in  32  MTC0 data
- hw_irq  in  N_HW_IRQ  asynchronous level interrupt lines
- exc_take  in  1  one-cycle pulse: commit exception entry
- exc_code  in  5  ExcCode for exc_take (0 = interrupt)
- exc_pc  in  32  PC saved to EPC on exc_take
- eret  in  1  one-cycle pulse: exception return
- int_req  out  1  interrupt pending and enabled, level
- epc  out  32  current EPC
- exl  out  1  current Status.EXL

## Operation
- Register map: Count=9, Compare=11, Status=12, Cause=13, EPC=14. Other indices read 0; writes to them are ignored.
- Status: bit0 IE, bit1 EXL, bits[15:8] IM. All other bits read 0. IE, EXL and IM are writable.
- Cause: [6:2] ExcCode, [15:8] IP. IP[1:0] are software bits, writable via MTC0. IP[2+i] = synchronised hw_irq[i], read-only. IP[7] = timer flag TI, read-only. Unused IP bits read 0.
- int_req = IE & ~EXL & |(IP & IM).
- Timer:
  - The prescaler counts 0..COUNT_DIV-1 and wraps.
  - On the wrap edge, Count <= Count+1, modulo 2^32.
  - If Count+1 == Compare on that edge, TI <= 1.
  - TI stays set until an MTC0 to Compare.
- MTC0 Count loads wdata and resets the prescaler. It does not set TI.
- exc_take: EPC <= exc_pc, ExcCode <= exc_code, EXL <= 1. IE is unchanged.
- eret: EXL <= 0.
- Simultaneous events, priority order:
  - exc_take beats eret.
  - exc_take beats MTC0 to the same field (EPC, ExcCode, EXL). MTC0 still updates the non-conflicting fields.
  - MTC0 Count beats the increment.
  - MTC0 Compare clear beats a same-edge TI set.
- exc_take while EXL=1: the fields are still overwritten (no nesting protection; the controller must not issue it).

## Timing
- Reset values:
  - Count, Status, Cause, EPC, TI and prescaler = 0; Compare = COMPARE_RST; sync flops = 0.
  - Outputs: int_req=0, epc=0, exl=0; rdata follows rd_addr.
- All register updates happen on the rising clk edge. rdata reflects the write from the following cycle on.
- hw_irq passes through a 2-flop synchroniser. A level present before edge k is visible in IP and int_req after edge k+1, i.e. 2 cycles of latency. Deassertion has the same latency; lines are not latched.
- TI is visible on int_req in the cycle after the matching increment edge.
- int_req drops in the cycle after the exc_take edge, because EXL is set.
- rst asserted mid-operation clears everything immediately. A pending exc_take in that cycle is lost.

## Structure
- Package cp0_pkg:
  - register index constants, Status/Cause bit positions
  - ExcCode constants: INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12
  - prescaler width function clog2(COUNT_DIV)
- Sub-module cp0_irq_sync: N_HW_IRQ-wide 2-flop synchroniser with async reset. Instantiated once.
- Everything else lives in one clocked process plus combinational read mux and int_req logic.

## Test plan
- Reset, then read regs 9/11/12/13/14 → 0, FFFF_FFFF, 0, 0, 0; int_req=0. Read reg 3 → 0.
- COUNT_DIV=2, Compare=5, Count=0 via MTC0 → TI sets on the 10th cycle after the write; int_req=1 only when Status=0x8001. MTC0 Compare=20 → TI=0 next cycle.
- hw_irq[0] raised, Status=0x0401 → int_req=1 exactly 2 cycles later. Drop hw_irq[0] → int_req=0 2 cycles later.
- exc_take with exc_pc=0x0000_0040, code 0 → EPC=0x40, Cause[6:2]=0, exl=1, int_req=0. eret → exl=0, int_req returns.
- Same-cycle exc_take and eret → exl=1. Same-cycle exc_take and MTC0 EPC=0x99 → EPC=exc_pc.
- Assert rst mid-count with TI=1 and EXL=1 → all registers and outputs at reset values before the next clk edge.
